battle_turn_sequencer: RTL and testbench

- Drives the battle engine's command inputs: `player_turn`, `player_choice`, `attacker_turn` and `enemy_choice`.
- Reads back HP, remaining weapons and win flags from the engine.
- Alternates turns: player first, then a delayed enemy AI move chosen with an LFSR.
- Blocks exhausted weapons on both sides and ends the battle on a win flag or when the collision drops.

---
 rtl/battle_pkg.sv | 36 +++
 rtl/battle_turn_sequencer_if.sv | 43 ++++
 rtl/enemy_ai_pick.sv | 23 ++
 rtl/battle_turn_sequencer.sv | 153 +++++++++++++++
 tb/tb_battle_turn_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/battle_pkg.sv
// Shared definitions for the battle turn sequencer and its enemy AI helpers:
// attack encodings, sequencer states, settle length and engine field widths.
package battle_pkg;

  localparam int HP_W       = 8;
  localparam int AMMO_W     = 5;
  localparam int SETTLE_LEN = 2;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ATK_P = 2'b00,
    ATK_K = 2'b01,
    ATK_B = 2'b10,
    ATK_S = 2'b11
  } attack_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P_WAIT,
    ST_P_SETTLE,
    ST_E_DELAY,
    ST_E_STRIKE,
    ST_E_SETTLE,
    ST_DONE
  } state_e;

  // A sword or bat attack needs at least one of that weapon left; punch and kick are free.
  function automatic logic weapon_available(input logic [1:0]        atk,
                                            input logic [AMMO_W-1:0] sword,
                                            input logic [AMMO_W-1:0] bat);
    return !(((atk == ATK_S) && (sword == '0)) || ((atk == ATK_B) && (bat == '0)));
  endfunction

endpackage

// File: rtl/battle_turn_sequencer_if.sv
// Command/status bundle between the turn sequencer and the battle engine / map logic.
interface battle_turn_sequencer_if;
  import battle_pkg::*;

  logic                collision_detected;
  logic                key_valid;
  logic [1:0]          key_choice;
  logic [HP_W-1:0]     player_HP;
  logic [HP_W-1:0]     enemy_HP;
  logic [AMMO_W-1:0]   player_remained_sword;
  logic [AMMO_W-1:0]   player_remained_baseballbat;
  logic [AMMO_W-1:0]   enemy_remained_sword;
  logic [AMMO_W-1:0]   enemy_remained_baseballbat;
  logic                player_win;
  logic                enemy_win;
  logic [1:0]          player_choice;
  logic [1:0]          enemy_choice;
  logic                player_turn;
  logic                attacker_turn;
  logic                key_reject;
  logic                turn_owner;
  logic                battle_active;
  logic                battle_over;

  // Sequencer side: reads engine status and key input, drives engine commands.
  modport master (
    input  collision_detected, key_valid, key_choice, player_HP, enemy_HP,
           player_remained_sword, player_remained_baseballbat,
           enemy_remained_sword, enemy_remained_baseballbat, player_win, enemy_win,
    output player_choice, enemy_choice, player_turn, attacker_turn, key_reject,
           turn_owner, battle_active, battle_over
  );

  // Environment side: engine, map logic and keypad.
  modport slave (
    output collision_detected, key_valid, key_choice, player_HP, enemy_HP,
           player_remained_sword, player_remained_baseballbat,
           enemy_remained_sword, enemy_remained_baseballbat, player_win, enemy_win,
    input  player_choice, enemy_choice, player_turn, attacker_turn, key_reject,
           turn_owner, battle_active, battle_over
  );

endinterface

// File: rtl/enemy_ai_pick.sv
// Turns a raw 2-bit enemy attack into a legal one given the enemy's remaining ammo.
// Sword falls back to bat, bat falls back to kick.
module enemy_ai_pick
  import battle_pkg::*;
(
  input  logic [1:0]        raw_i,
  input  logic [AMMO_W-1:0] sword_i,
  input  logic [AMMO_W-1:0] bat_i,
  output logic [1:0]        pick_o
);

  attack_e pick_c;

  // Downgrade chain: an exhausted sword becomes bat, and the bat check runs after so both can chain.
  always_comb begin
    pick_c = attack_e'(raw_i);
    if ((pick_c == ATK_S) && (sword_i == '0)) pick_c = ATK_B;
    if ((pick_c == ATK_B) && (bat_i == '0))   pick_c = ATK_K;
  end

  assign pick_o = pick_c;

endmodule

// File: rtl/battle_turn_sequencer.sv
// Battle turn sequencer: player strikes on a key, the enemy strikes after a delay
// with an LFSR-driven choice, and the battle ends on a win flag or on loss of collision.
module battle_turn_sequencer
  import battle_pkg::*;
#(
  parameter int          ENEMY_DELAY = 50000000,
  parameter int          DELAY_W     = 26,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic                     clk,
  input logic                     rst,
  battle_turn_sequencer_if.master bt
);

  localparam logic [DELAY_W-1:0] DLY_LAST    = DELAY_W'(ENEMY_DELAY - 1);
  localparam logic [DELAY_W-1:0] SETTLE_LAST = DELAY_W'(SETTLE_LEN - 1);

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [15:0]        lfsr_q;
  logic               coll_q;
  logic               p_fire, e_fire, rej;
  logic [1:0]         ai_pick;
  logic               win_any;
  logic               key_ok;

  logic [1:0]         player_choice_q, enemy_choice_q;
  logic               player_turn_q, attacker_turn_q, key_reject_q;
  logic               turn_owner_q, battle_active_q, battle_over_q;

  // HP is carried on the bus for observers; turn decisions only use ammo and win flags.
  logic unused_hp;
  assign unused_hp = ^{bt.player_HP, bt.enemy_HP};

  assign win_any = bt.player_win | bt.enemy_win;
  assign key_ok  = weapon_available(bt.key_choice, bt.player_remained_sword,
                                    bt.player_remained_baseballbat);

  enemy_ai_pick u_ai (
    .raw_i   (lfsr_q[1:0]),
    .sword_i (bt.enemy_remained_sword),
    .bat_i   (bt.enemy_remained_baseballbat),
    .pick_o  (ai_pick)
  );

  // Next-state and strike/reject decisions; losing collision overrides everything else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_fire  = 1'b0;
    e_fire  = 1'b0;
    rej     = 1'b0;
    if ((state_q != ST_IDLE) && !bt.collision_detected) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (bt.collision_detected && !coll_q) state_d = ST_P_WAIT;
        end
        ST_P_WAIT: begin
          if (bt.key_valid) begin
            if (!key_ok) begin
              rej = 1'b1;
            end else begin
              p_fire  = 1'b1;
              state_d = ST_P_SETTLE;
              cnt_d   = '0;
            end
          end
        end
        ST_P_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = win_any ? ST_DONE : ST_E_DELAY;
          end else begin
            cnt_d = cnt_q + DELAY_W'(1);
          end
        end
        ST_E_DELAY: begin
          if (cnt_q == DLY_LAST) begin
            cnt_d   = '0;
            state_d = ST_E_STRIKE;
          end else begin
            cnt_d = cnt_q + DELAY_W'(1);
          end
        end
        ST_E_STRIKE: begin
          e_fire  = 1'b1;
          cnt_d   = '0;
          state_d = ST_E_SETTLE;
        end
        ST_E_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = win_any ? ST_DONE : ST_P_WAIT;
          end else begin
            cnt_d = cnt_q + DELAY_W'(1);
          end
        end
        ST_DONE: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters, LFSR, collision history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      lfsr_q          <= LFSR_SEED;
      coll_q          <= 1'b0;
      player_choice_q <= 2'b00;
      enemy_choice_q  <= 2'b00;
      player_turn_q   <= 1'b0;
      attacker_turn_q <= 1'b0;
      key_reject_q    <= 1'b0;
      turn_owner_q    <= 1'b0;
      battle_active_q <= 1'b0;
      battle_over_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      lfsr_q          <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      coll_q          <= bt.collision_detected;
      player_turn_q   <= p_fire;
      attacker_turn_q <= e_fire;
      key_reject_q    <= rej;
      if (p_fire) player_choice_q <= bt.key_choice;
      if (e_fire) enemy_choice_q  <= ai_pick;
      turn_owner_q    <= (state_d inside {ST_E_DELAY, ST_E_STRIKE, ST_E_SETTLE});
      battle_active_q <= (state_d != ST_IDLE);
      battle_over_q   <= (state_d == ST_DONE);
    end
  end

  assign bt.player_choice = player_choice_q;
  assign bt.enemy_choice  = enemy_choice_q;
  assign bt.player_turn   = player_turn_q;
  assign bt.attacker_turn = attacker_turn_q;
  assign bt.key_reject    = key_reject_q;
  assign bt.turn_owner    = turn_owner_q;
  assign bt.battle_active = battle_active_q;
  assign bt.battle_over   = battle_over_q;

endmodule

// File: tb/tb_battle_turn_sequencer.sv
// Self-checking bench for battle_turn_sequencer with a short enemy delay.
module tb_battle_turn_sequencer;

  localparam int          DLY      = 4;
  localparam int          SETTLE   = 2;
  localparam logic [15:0] SEED     = 16'hACE1;
  // Cycle offsets from the player pulse: settle, delay, strike cycle, then enemy settle.
  localparam int          AT_IDX   = SETTLE + DLY + 1;
  localparam int          PW_IDX   = AT_IDX + SETTLE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec  = 0;
  int   errs = 0;

  battle_turn_sequencer_if bt ();

  battle_turn_sequencer #(
    .ENEMY_DELAY (DLY),
    .DELAY_W     (26),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bt  (bt)
  );

  always #5 clk = ~clk;

  // Reference LFSR: polynomial x^16+x^14+x^13+x^11+1, one step per clock.
  logic [15:0] m_lfsr, m_lfsr_prev;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] mask;
    mask = 16'((1 << 15) | (1 << 13) | (1 << 12) | (1 << 10));
    return v[0] ? ((v >> 1) ^ mask) : (v >> 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr      <= SEED;
      m_lfsr_prev <= SEED;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= lfsr_next(m_lfsr);
    end
  end

  function automatic logic [1:0] m_pick(input logic [1:0] raw, input int s, input int b);
    logic [1:0] c;
    c = raw;
    if (c == 2'd3 && s == 0) c = 2'd2;
    if (c == 2'd2 && b == 0) c = 2'd1;
    return c;
  endfunction

  function automatic bit m_legal(input logic [1:0] k, input int s, input int b);
    return !((k == 2'd3 && s == 0) || (k == 2'd2 && b == 0));
  endfunction

  function automatic int first_one(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Observation record of one turn, index 0 = cycle after the key is sampled.
  logic [15:0] o_pt, o_at, o_to, o_kr, o_ba, o_bo;
  logic [1:0]  o_pc [16];
  logic [1:0]  o_ec [16];
  logic [1:0]  o_raw[16];

  function automatic logic [9:0] all_outs();
    return {bt.player_choice, bt.enemy_choice, bt.player_turn, bt.attacker_turn,
            bt.key_reject, bt.turn_owner, bt.battle_active, bt.battle_over};
  endfunction

  task automatic set_ammo(input int ps, input int pb, input int es, input int eb);
    bt.player_remained_sword       = 5'(ps);
    bt.player_remained_baseballbat = 5'(pb);
    bt.enemy_remained_sword        = 5'(es);
    bt.enemy_remained_baseballbat  = 5'(eb);
  endtask

  // Press a key for one cycle and record n cycles; ev_kind 1/2/3 raise win flags, 4 drops collision.
  task automatic watch(input logic [1:0] k, input int n, input int ev_at, input int ev_kind);
    o_pt = '0; o_at = '0; o_to = '0; o_kr = '0; o_ba = '0; o_bo = '0;
    bt.key_choice = k;
    bt.key_valid  = 1'b1;
    @(negedge clk);
    bt.key_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      o_pt[i] = bt.player_turn;  o_at[i] = bt.attacker_turn; o_to[i] = bt.turn_owner;
      o_kr[i] = bt.key_reject;   o_ba[i] = bt.battle_active; o_bo[i] = bt.battle_over;
      o_pc[i] = bt.player_choice; o_ec[i] = bt.enemy_choice; o_raw[i] = m_lfsr_prev[1:0];
      if (i == ev_at) begin
        case (ev_kind)
          1: bt.player_win = 1'b1;
          2: bt.enemy_win  = 1'b1;
          3: begin bt.player_win = 1'b1; bt.enemy_win = 1'b1; end
          4: bt.collision_detected = 1'b0;
          default: ;
        endcase
      end
      if (i < n - 1) @(negedge clk);
    end
  endtask

  task automatic start_battle();
    bt.collision_detected = 1'b0;
    @(negedge clk);
    bt.collision_detected = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bt.collision_detected = 1'b1;
    repeat (2) @(negedge clk);
    vec++;
    if (all_outs() !== 10'd0) begin
      errs++; $display("FAIL reset_outs got=%b want=%b", all_outs(), 10'd0);
    end
    bt.collision_detected = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if ({bt.battle_active, bt.battle_over} !== 2'b00) begin
      errs++; $display("FAIL idle_no_collision got=%b want=00", {bt.battle_active, bt.battle_over});
    end
  endtask

  task automatic test_start();
    bt.collision_detected = 1'b1;
    @(negedge clk);
    vec++;
    if ({bt.battle_active, bt.turn_owner, bt.player_turn, bt.attacker_turn, bt.key_reject,
         bt.battle_over} !== 6'b100000) begin
      errs++; $display("FAIL start got=%b want=100000", {bt.battle_active, bt.turn_owner,
        bt.player_turn, bt.attacker_turn, bt.key_reject, bt.battle_over});
    end
  endtask

  task automatic test_player_punch();
    int es, eb;
    logic [1:0] exp;
    es = $urandom_range(1, 31); eb = $urandom_range(1, 31);
    set_ammo($urandom_range(1, 31), $urandom_range(1, 31), es, eb);
    watch(2'b00, PW_IDX + 1, -1, 0);
    vec++;
    if ({o_pt[0], o_pc[0]} !== 3'b100) begin
      errs++; $display("FAIL punch_pulse got=%b want=100", {o_pt[0], o_pc[0]});
    end
    vec++;
    if ($countones(o_pt) != 1 || $countones(o_at) != 1) begin
      errs++; $display("FAIL punch_pulse_counts got pt=%0d at=%0d want 1 1", $countones(o_pt), $countones(o_at));
    end
    vec++;
    if (first_one(o_at) != AT_IDX) begin
      errs++; $display("FAIL punch_enemy_latency got=%0d want=%0d", first_one(o_at), AT_IDX);
    end
    exp = m_pick(o_raw[AT_IDX], es, eb);
    vec++;
    if (o_ec[AT_IDX] !== exp || o_ec[PW_IDX] !== exp) begin
      errs++; $display("FAIL punch_enemy_choice got=%b/%b want=%b", o_ec[AT_IDX], o_ec[PW_IDX], exp);
    end
    vec++;
    if ({o_to[0], o_to[3], o_to[PW_IDX-1], o_to[PW_IDX]} !== 4'b0110) begin
      errs++; $display("FAIL punch_turn_owner got=%b want=0110",
        {o_to[0], o_to[3], o_to[PW_IDX-1], o_to[PW_IDX]});
    end
  endtask

  task automatic test_exhausted();
    set_ammo(0, 5, 3, 3);
    bt.key_choice = 2'b11; bt.key_valid = 1'b1;
    @(negedge clk);
    bt.key_valid = 1'b0;
    vec++;
    if ({bt.key_reject, bt.player_turn} !== 2'b10) begin
      errs++; $display("FAIL sword_reject got=%b want=10", {bt.key_reject, bt.player_turn});
    end
    @(negedge clk);
    vec++;
    if ({bt.key_reject, bt.player_turn, bt.turn_owner, bt.battle_active} !== 4'b0001) begin
      errs++; $display("FAIL reject_stays got=%b want=0001",
        {bt.key_reject, bt.player_turn, bt.turn_owner, bt.battle_active});
    end
    set_ammo(4, 0, 3, 3);
    bt.key_choice = 2'b10; bt.key_valid = 1'b1;
    @(negedge clk);
    bt.key_valid = 1'b0;
    vec++;
    if ({bt.key_reject, bt.player_turn} !== 2'b10) begin
      errs++; $display("FAIL bat_reject got=%b want=10", {bt.key_reject, bt.player_turn});
    end
    @(negedge clk);
    set_ammo(0, 5, 3, 3);
    watch(2'b01, PW_IDX + 1, -1, 0);
    vec++;
    if ({o_pt[0], o_pc[0], o_kr[0], first_one(o_at) == AT_IDX} !== 5'b10101) begin
      errs++; $display("FAIL kick_after_reject got=%b want=10101",
        {o_pt[0], o_pc[0], o_kr[0], first_one(o_at) == AT_IDX});
    end
  endtask

  task automatic test_random_rounds();
    int ps, pb, es, eb;
    logic [1:0] k, exp;
    for (int r = 0; r < 30; r++) begin
      ps = $urandom_range(0, 2); pb = $urandom_range(0, 2);
      es = $urandom_range(0, 2); eb = $urandom_range(0, 2);
      k  = 2'($urandom_range(0, 3));
      set_ammo(ps, pb, es, eb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (!m_legal(k, ps, pb)) begin
        bt.key_choice = k; bt.key_valid = 1'b1;
        @(negedge clk);
        bt.key_valid = 1'b0;
        vec++;
        if ({bt.key_reject, bt.player_turn} !== 2'b10) begin
          errs++; $display("FAIL rnd_reject r=%0d k=%0d got=%b want=10", r, k, {bt.key_reject, bt.player_turn});
        end
        @(negedge clk);
      end else begin
        watch(k, PW_IDX + 1, -1, 0);
        exp = m_pick(o_raw[AT_IDX], es, eb);
        vec++;
        if ({o_pt[0], o_pc[0], o_kr[0], o_at[AT_IDX], o_ec[AT_IDX], o_to[PW_IDX]} !== {1'b1, k, 1'b0, 1'b1, exp, 1'b0}) begin
          errs++; $display("FAIL rnd_turn r=%0d got pt=%b pc=%b kr=%b at=%b ec=%b to=%b want pc=%b ec=%b",
            r, o_pt[0], o_pc[0], o_kr[0], o_at[AT_IDX], o_ec[AT_IDX], o_to[PW_IDX], k, exp);
        end
        vec++;
        if (|(o_pt & (o_at | (o_at << 1) | (o_at >> 1))) || $countones(o_pt) != 1 || $countones(o_at) != 1) begin
          errs++; $display("FAIL rnd_pulse_invariant r=%0d pt=%b at=%b", r, o_pt, o_at);
        end
      end
    end
  endtask

  task automatic test_enemy_downgrade();
    int eb;
    bit hit0, hit3;
    logic [1:0] exp;
    hit0 = 0; hit3 = 0;
    for (int r = 0; r < 40 && !(hit0 && hit3); r++) begin
      eb = (r % 2 == 1) ? 3 : 0;
      set_ammo(5, 5, 0, eb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      watch(2'b00, PW_IDX + 1, -1, 0);
      if (o_raw[AT_IDX] == 2'b11) begin
        exp = (eb == 0) ? 2'b01 : 2'b10;
        if (eb == 0) hit0 = 1; else hit3 = 1;
      end else begin
        exp = m_pick(o_raw[AT_IDX], 0, eb);
      end
      vec++;
      if ({o_at[AT_IDX], o_ec[AT_IDX]} !== {1'b1, exp}) begin
        errs++; $display("FAIL downgrade r=%0d raw=%b bat=%0d got at=%b ec=%b want ec=%b",
          r, o_raw[AT_IDX], eb, o_at[AT_IDX], o_ec[AT_IDX], exp);
      end
    end
    vec++;
    if ({hit0, hit3} !== 2'b11) begin
      errs++; $display("FAIL downgrade_coverage got=%b want=11", {hit0, hit3});
    end
  endtask

  task automatic test_win();
    set_ammo(5, 5, 5, 5);
    watch(2'b00, 6, 1, 1);
    vec++;
    if ({o_bo[1], o_bo[2], o_ba[5], o_to[5], o_at} !== {4'b0110, 16'h0}) begin
      errs++; $display("FAIL player_win got=%b want=0110 no attacker", {o_bo[1], o_bo[2], o_ba[5], o_to[5], o_at});
    end
    bt.key_choice = 2'b00; bt.key_valid = 1'b1;
    @(negedge clk);
    bt.key_valid = 1'b0;
    vec++;
    if ({bt.player_turn, bt.key_reject, bt.battle_over} !== 3'b001) begin
      errs++; $display("FAIL key_in_done got=%b want=001", {bt.player_turn, bt.key_reject, bt.battle_over});
    end
    bt.collision_detected = 1'b0;
    @(negedge clk);
    vec++;
    if ({bt.battle_active, bt.battle_over} !== 2'b00) begin
      errs++; $display("FAIL done_to_idle got=%b want=00", {bt.battle_active, bt.battle_over});
    end
    bt.player_win = 1'b0;
    start_battle();
    watch(2'b01, PW_IDX + 2, AT_IDX, 2);
    vec++;
    if ({o_at[AT_IDX], o_bo[PW_IDX-1], o_bo[PW_IDX], o_ba[PW_IDX+1]} !== 4'b1011) begin
      errs++; $display("FAIL enemy_win got=%b want=1011", {o_at[AT_IDX], o_bo[PW_IDX-1], o_bo[PW_IDX], o_ba[PW_IDX+1]});
    end
    bt.collision_detected = 1'b0;
    bt.enemy_win = 1'b0;
    @(negedge clk);
    start_battle();
    watch(2'b00, 6, 1, 3);
    vec++;
    if ({o_bo[2], o_at} !== {1'b1, 16'h0}) begin
      errs++; $display("FAIL both_win got=%b want=1 no attacker", {o_bo[2], o_at});
    end
    bt.collision_detected = 1'b0;
    bt.player_win = 1'b0; bt.enemy_win = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    set_ammo(5, 5, 5, 5);
    start_battle();
    watch(2'b00, PW_IDX + 3, 3, 4);
    vec++;
    if ({o_to[3], o_ba[3], o_ba[4], o_bo, o_at} !== {3'b110, 16'h0, 16'h0}) begin
      errs++; $display("FAIL abort_e_delay got to=%b ba3=%b ba4=%b bo=%h at=%h",
        o_to[3], o_ba[3], o_ba[4], o_bo, o_at);
    end
    start_battle();
    bt.key_choice = 2'b01; bt.key_valid = 1'b1; bt.collision_detected = 1'b0;
    @(negedge clk);
    bt.key_valid = 1'b0;
    vec++;
    if ({bt.player_turn, bt.key_reject, bt.battle_active} !== 3'b000) begin
      errs++; $display("FAIL abort_with_key got=%b want=000", {bt.player_turn, bt.key_reject, bt.battle_active});
    end
    start_battle();
    vec++;
    if ({bt.battle_active, bt.turn_owner, bt.battle_over} !== 3'b100) begin
      errs++; $display("FAIL restart got=%b want=100", {bt.battle_active, bt.turn_owner, bt.battle_over});
    end
  endtask

  task automatic test_async_reset();
    set_ammo(5, 5, 5, 5);
    bt.key_choice = 2'b01; bt.key_valid = 1'b1;
    @(posedge clk);
    #1;
    bt.key_valid = 1'b0;
    vec++;
    if ({bt.player_turn, bt.player_choice} !== 3'b101) begin
      errs++; $display("FAIL pre_reset_pulse got=%b want=101", {bt.player_turn, bt.player_choice});
    end
    #2;
    rst = 1'b1;
    #1;
    vec++;
    if (all_outs() !== 10'd0) begin
      errs++; $display("FAIL async_reset got=%b want=%b", all_outs(), 10'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec++;
    if ({bt.battle_active, bt.turn_owner, bt.player_turn} !== 3'b100) begin
      errs++; $display("FAIL restart_after_reset got=%b want=100", {bt.battle_active, bt.turn_owner, bt.player_turn});
    end
    bt.collision_detected = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired vectors=%0d", vec);
    $fatal(1, "watchdog");
  end

  initial begin
    bt.collision_detected = 1'b0;
    bt.key_valid  = 1'b0;
    bt.key_choice = 2'b00;
    bt.player_HP  = 8'd100;
    bt.enemy_HP   = 8'd80;
    bt.player_win = 1'b0;
    bt.enemy_win  = 1'b0;
    set_ammo(5, 5, 5, 5);
    test_reset();
    test_start();
    test_player_punch();
    test_exhausted();
    test_random_rounds();
    test_enemy_downgrade();
    test_win();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
